// File: rtl/gbe_rst_sequencer.sv
// gbe_rst_sequencer: power-on/software core reset pulse, link-up wait with timeout, TX gating and status readback.
// Optional macro GBE_RST_AUTO_RETRY_EN re-runs the reset sequence on timeout up to MAX_RETRIES times.
module gbe_rst_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LINK_TIMEOUT = 1024,
  parameter int MAX_RETRIES  = 3
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic [31:0] ctrl_in,
  input  logic        link_up,
  output logic        gbe_rst,
  output logic        tx_en,
  output logic [31:0] status_out
);
  typedef enum logic [2:0] {IDLE = 3'd0, RESET = 3'd1, WAIT_LINK = 3'd2, RUN = 3'd3, FAULT = 3'd4} state_t;
  localparam int PW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [PW-1:0] P_LAST = PW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(LINK_TIMEOUT - 1);
  state_t        r_state;
  logic [PW-1:0] r_pcnt;
  logic [TW-1:0] r_tcnt;
  logic [7:0]    r_rst_count;
  logic          r_timeout_flag;
  logic          r_prev;
  logic [31:0]   r_status;
  logic [7:0]    w_retry_cnt;
  logic          w_may_retry;
  logic          w_restart;
  logic          w_unused;
  assign w_restart  = ctrl_in[0] & ~r_prev & (r_state != RESET);
  assign gbe_rst    = (r_state == RESET);
  assign tx_en      = (r_state == RUN) & ctrl_in[1];
  assign status_out = r_status;
`ifdef GBE_RST_AUTO_RETRY_EN
  logic [7:0] r_retry_cnt;
  logic       w_timeout;
  assign w_timeout   = (r_state == WAIT_LINK) & ~link_up & (r_tcnt == T_LAST);
  assign w_may_retry = (r_retry_cnt < 8'(MAX_RETRIES));
  assign w_retry_cnt = r_retry_cnt;
  assign w_unused    = ^ctrl_in[31:2];
  always_ff @(posedge user_clk) begin
    if (user_rst || w_restart || (r_state == WAIT_LINK && link_up)) r_retry_cnt <= 8'd0;
    else if (w_timeout && w_may_retry) r_retry_cnt <= r_retry_cnt + 8'd1;
  end
`else
  assign w_may_retry = 1'b0;
  assign w_retry_cnt = 8'd0;
  assign w_unused    = ^{ctrl_in[31:2], 8'(MAX_RETRIES)};
`endif
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_state        <= RESET;
      r_pcnt         <= '0;
      r_tcnt         <= '0;
      r_rst_count    <= 8'd0;
      r_timeout_flag <= 1'b0;
      r_prev         <= 1'b0;
      r_status       <= 32'd1;
    end else begin
      r_prev   <= ctrl_in[0];
      r_status <= {8'd0, w_retry_cnt, r_rst_count, 3'd0, r_timeout_flag, link_up, r_state};
      // a software request outranks any link or timeout event this cycle
      if (w_restart) begin
        r_state        <= RESET;
        r_pcnt         <= '0;
        r_rst_count    <= r_rst_count + 8'd1;
        r_timeout_flag <= 1'b0;
      end else begin
        case (r_state)
          RESET: begin
            if (r_pcnt == P_LAST) begin
              r_state <= WAIT_LINK;
              r_tcnt  <= '0;
            end else r_pcnt <= r_pcnt + 1'b1;
          end
          WAIT_LINK: begin
            if (link_up) r_state <= RUN;
            else if (r_tcnt == T_LAST) begin
              r_timeout_flag <= 1'b1;
              if (w_may_retry) begin
                r_state     <= RESET;
                r_pcnt      <= '0;
                r_rst_count <= r_rst_count + 8'd1;
              end else r_state <= FAULT;
            end else r_tcnt <= r_tcnt + 1'b1;
          end
          RUN: begin
            if (!link_up) begin
              r_state <= WAIT_LINK;
              r_tcnt  <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gbe_rst_sequencer.sv
// tb_gbe_rst_sequencer: table vectors, directed corner sequences and randomized traffic against a phase/age model.
module tb_gbe_rst_sequencer;
  localparam int RC = 4, LT = 20, MR = 2;
`ifdef GBE_RST_AUTO_RETRY_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic        user_clk = 1'b0;
  logic        user_rst = 1'b1;
  logic [31:0] ctrl_in = 32'h2;
  logic        link_up = 1'b1;
  logic        gbe_rst, tx_en;
  logic [31:0] status_out;
  int checks = 0, failures = 0;
  int m_mode, m_age, m_rc, m_rt;
  bit m_to, m_prev;
  logic [31:0] m_status;

  always #5 user_clk = ~user_clk;

  gbe_rst_sequencer #(.RST_CYCLES(RC), .LINK_TIMEOUT(LT), .MAX_RETRIES(MR)) dut (
    .user_clk(user_clk), .user_rst(user_rst), .ctrl_in(ctrl_in), .link_up(link_up),
    .gbe_rst(gbe_rst), .tx_en(tx_en), .status_out(status_out));

  typedef struct {
    bit          rst;
    logic [31:0] ctrl;
    bit          link;
    bit          exp_rst;
    bit          exp_tx;
    logic [31:0] exp_status;
  } vec_t;
  vec_t vt[9];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // phase: 1 = core in reset, 2 = waiting for link, 3 = running, 4 = fault; age = cycles spent in phase
  task automatic model_step();
    bit e;
    if (user_rst) begin
      m_mode = 1; m_age = 0; m_rc = 0; m_rt = 0; m_to = 0; m_prev = 0; m_status = 32'd1;
      return;
    end
    e = ctrl_in[0] && !m_prev;
    m_prev = ctrl_in[0];
    m_status = {8'd0, 8'(m_rt), 8'(m_rc), 3'd0, m_to, link_up, 3'(m_mode)};
    if (e && m_mode != 1) begin
      m_mode = 1; m_age = 0; m_rc = (m_rc + 1) % 256; m_rt = 0; m_to = 0;
    end else if (m_mode == 1) begin
      m_age++;
      if (m_age == RC) begin m_mode = 2; m_age = 0; end
    end else if (m_mode == 2) begin
      if (link_up) begin m_mode = 3; m_rt = 0; end
      else begin
        m_age++;
        if (m_age == LT) begin
          m_to = 1;
          if (AUTO && m_rt < MR) begin m_mode = 1; m_age = 0; m_rt++; m_rc = (m_rc + 1) % 256; end
          else m_mode = 4;
        end
      end
    end else if (m_mode == 3 && !link_up) begin
      m_mode = 2; m_age = 0;
    end
  endtask

  task automatic tick(input bit cmp);
    @(posedge user_clk);
    model_step();
    #1;
    if (cmp) begin
      check("model_gbe_rst", 32'(gbe_rst), 32'(m_mode == 1));
      check("model_tx_en", 32'(tx_en), 32'(m_mode == 3 && ctrl_in[1]));
      check("model_status", status_out, m_status);
    end
  endtask

  initial begin
    int cnt;
    vt[0] = '{1'b1, 32'h2, 1'b1, 1'b1, 1'b0, 32'h1};
    vt[1] = vt[0];
    vt[2] = vt[0];
    vt[3] = '{1'b0, 32'h2, 1'b1, 1'b1, 1'b0, 32'h9};
    vt[4] = vt[3];
    vt[5] = vt[3];
    vt[6] = '{1'b0, 32'h2, 1'b1, 1'b0, 1'b0, 32'h9};
    vt[7] = '{1'b0, 32'h2, 1'b1, 1'b0, 1'b1, 32'hA};
    vt[8] = '{1'b0, 32'h2, 1'b1, 1'b0, 1'b1, 32'hB};
    for (int i = 0; i < 9; i++) begin
      user_rst = vt[i].rst; ctrl_in = vt[i].ctrl; link_up = vt[i].link;
      tick(1'b0);
      check($sformatf("vec%0d_gbe_rst", i), 32'(gbe_rst), 32'(vt[i].exp_rst));
      check($sformatf("vec%0d_tx_en", i), 32'(tx_en), 32'(vt[i].exp_tx));
      check($sformatf("vec%0d_status", i), status_out, vt[i].exp_status);
    end
    // edge in RUN, level held high
    ctrl_in = 32'h3;
    tick(1'b1);
    check("t2_pulse_starts", 32'(gbe_rst), 32'd1);
    cnt = 1;
    for (int i = 0; i < 49; i++) begin tick(1'b1); cnt += int'(gbe_rst); end
    check("t2_pulse_len", 32'(cnt), 32'd4);
    check("t2_rst_count", 32'(status_out[15:8]), 32'd1);
    // second edge inside the pulse
    ctrl_in = 32'h2; tick(1'b1);
    ctrl_in = 32'h3; cnt = 0;
    tick(1'b1); cnt += int'(gbe_rst);
    tick(1'b1); cnt += int'(gbe_rst);
    ctrl_in = 32'h2; tick(1'b1); cnt += int'(gbe_rst);
    ctrl_in = 32'h3; tick(1'b1); cnt += int'(gbe_rst);
    for (int i = 0; i < 10; i++) begin tick(1'b1); cnt += int'(gbe_rst); end
    check("t3_pulse_len", 32'(cnt), 32'd4);
    check("t3_rst_count", 32'(status_out[15:8]), 32'd2);
    // link never comes up
    link_up = 1'b0; ctrl_in = 32'h2; tick(1'b1);
    ctrl_in = 32'h3; cnt = 0;
    for (int i = 0; i < (AUTO ? 74 : 26); i++) begin tick(1'b1); cnt += int'(gbe_rst); end
    check("t4_fault_state", 32'(status_out[2:0]), 32'd4);
    check("t4_timeout_flag", 32'(status_out[4]), 32'd1);
    check("t4_pulse_cycles", 32'(cnt), AUTO ? 32'd12 : 32'd4);
    check("t4_rst_count", 32'(status_out[15:8]), AUTO ? 32'd5 : 32'd3);
    check("t4_retry_cnt", 32'(status_out[23:16]), AUTO ? 32'd2 : 32'd0);
    ctrl_in = 32'h2; tick(1'b1);
    ctrl_in = 32'h3; tick(1'b1);
    check("t4_fault_exit", 32'(gbe_rst), 32'd1);
    tick(1'b1);
    check("t4_flag_cleared", 32'(status_out[4]), 32'd0);
    // link arrives during the second wait (retry build) or while faulted
    for (int i = 0; i < 32; i++) tick(1'b1);
    check("t5_retry_midway", 32'(status_out[23:16]), AUTO ? 32'd1 : 32'd0);
    link_up = 1'b1; tick(1'b1); tick(1'b1);
    check("t5_state", 32'(status_out[2:0]), AUTO ? 32'd3 : 32'd4);
    check("t5_retry_clear", 32'(status_out[23:16]), 32'd0);
    // link drop in RUN, link on last timeout cycle, edge on last timeout cycle
    ctrl_in = 32'h2; tick(1'b1);
    ctrl_in = 32'h3;
    for (int i = 0; i < 7; i++) tick(1'b1);
    check("t6_running_tx", 32'(tx_en), 32'd1);
    link_up = 1'b0; tick(1'b1);
    check("t6_drop_tx", 32'(tx_en), 32'd0);
    check("t6_drop_no_rst", 32'(gbe_rst), 32'd0);
    tick(1'b1);
    check("t6_wait_state", 32'(status_out[2:0]), 32'd2);
    for (int i = 0; i < 18; i++) tick(1'b1);
    link_up = 1'b1; tick(1'b1); tick(1'b1);
    check("t6_late_link_run", 32'(status_out[2:0]), 32'd3);
    check("t6_late_link_flag", 32'(status_out[4]), 32'd0);
    ctrl_in = 32'h2; link_up = 1'b0; tick(1'b1);
    for (int i = 0; i < 19; i++) tick(1'b1);
    ctrl_in = 32'h3; tick(1'b1);
    check("t6_edge_wins", 32'(gbe_rst), 32'd1);
    tick(1'b1);
    check("t6_edge_state", 32'(status_out[2:0]), 32'd1);
    check("t6_edge_flag", 32'(status_out[4]), 32'd0);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      user_rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) ctrl_in = $urandom;
      if ($urandom_range(0, 29) == 0) link_up = ~link_up;
      tick(1'b1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
